// File: rtl/traffic_intersection_if.sv
// Signal bundle between an intersection controller and its lamp/pedestrian I/O.
// Pure wiring: no storage, so no added latency.
// No backpressure: all signals are level-valued and are sampled every clock.
interface traffic_intersection_if;
    logic       ped_req;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ns_pass;
    logic       ew_pass;
    logic       walk;
    logic       ped_wait;

    // Controller side: takes the request, drives the lamps and status flags.
    modport master (
        input  ped_req,
        output ns_light, ew_light, ns_pass, ew_pass, walk, ped_wait
    );

    // Field side: raises requests, observes the lamps.
    modport slave (
        output ped_req,
        input  ns_light, ew_light, ns_pass, ew_pass, walk, ped_wait
    );
endinterface

// File: rtl/traffic_intersection.sv
// Two-road intersection controller with all-red clearance and a latched pedestrian walk phase.
// Lamps change on the edge that ends a phase; all outputs decode from registers only.
// No backpressure: ped_req is level-sampled each clock and merged into one pending flag.
module traffic_intersection #(
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 2,
    parameter int CLEAR_CYCLES  = 1,
    parameter int WALK_CYCLES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_intersection_if.master  bus
);

    typedef enum logic [2:0] {
        NS_GREEN    = 3'd0,
        NS_YELLOW   = 3'd1,
        CLEAR_TO_EW = 3'd2,
        EW_GREEN    = 3'd3,
        EW_YELLOW   = 3'd4,
        CLEAR_TO_NS = 3'd5,
        WALK        = 3'd6
    } state_t;

    // Direction served after a walk phase.
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // Terminal counter values: a phase of D clocks ends when cnt reaches D-1.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES  - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES  - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYCLES   - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_wait_q, ped_wait_d;
    logic             next_dir_q, next_dir_d;
    logic [CNT_W-1:0] phase_last;
    logic             phase_done;

    // State, phase counter, pending request and post-walk direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NS_GREEN;
            cnt_q      <= '0;
            ped_wait_q <= 1'b0;
            next_dir_q <= DIR_EW;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_wait_q <= ped_wait_d;
            next_dir_q <= next_dir_d;
        end
    end

    // Next-state: advance at the end of each phase, diverting a clearance into WALK when a request is pending.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        next_dir_d = next_dir_q;
        phase_last = GREEN_LAST;

        case (state_q)
            NS_GREEN, EW_GREEN:       phase_last = GREEN_LAST;
            NS_YELLOW, EW_YELLOW:     phase_last = YELLOW_LAST;
            CLEAR_TO_EW, CLEAR_TO_NS: phase_last = CLEAR_LAST;
            WALK:                     phase_last = WALK_LAST;
            default:                  phase_last = GREEN_LAST;
        endcase

        phase_done = (cnt_q == phase_last);

        if (phase_done) begin
            cnt_d = '0;
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = CLEAR_TO_EW;
                CLEAR_TO_EW: begin
                    if (ped_wait_q) begin
                        state_d    = WALK;
                        next_dir_d = DIR_EW;
                    end else begin
                        state_d    = EW_GREEN;
                    end
                end
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = CLEAR_TO_NS;
                CLEAR_TO_NS: begin
                    if (ped_wait_q) begin
                        state_d    = WALK;
                        next_dir_d = DIR_NS;
                    end else begin
                        state_d    = NS_GREEN;
                    end
                end
                WALK:      state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
                default:   state_d = NS_GREEN;
            endcase
        end

        // Any edge whose next state is WALK (entering or staying) clears and blocks the request flag;
        // the edge leaving WALK already accepts new requests.
        if (state_d == WALK) begin
            ped_wait_d = 1'b0;
        end else begin
            ped_wait_d = ped_wait_q | bus.ped_req;
        end
    end

    // Output decode from registered state only: clearance and walk show all-red.
    always_comb begin
        bus.ns_light = 2'b00;
        bus.ew_light = 2'b00;
        bus.walk     = 1'b0;
        case (state_q)
            NS_GREEN:  bus.ns_light = 2'b10;
            NS_YELLOW: bus.ns_light = 2'b01;
            EW_GREEN:  bus.ew_light = 2'b10;
            EW_YELLOW: bus.ew_light = 2'b01;
            WALK:      bus.walk     = 1'b1;
            default:   ;
        endcase
        bus.ns_pass  = (bus.ns_light != 2'b00);
        bus.ew_pass  = (bus.ew_light != 2'b00);
        bus.ped_wait = ped_wait_q;
    end

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed bench for traffic_intersection: default instance plus a G=3/Y=1/C=2/W=2 instance.
// Outputs are sampled 1 time unit after each rising edge; index N counts edges since reset.
// Each observation packs {ns_light, ew_light, ns_pass, ew_pass, walk, ped_wait}.
module tb_traffic_intersection;

    localparam logic [1:0] LG = 2'b10;
    localparam logic [1:0] LY = 2'b01;
    localparam logic [1:0] LR = 2'b00;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    traffic_intersection_if bus_a ();
    traffic_intersection_if bus_b ();

    traffic_intersection dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    traffic_intersection #(
        .GREEN_CYCLES  (3),
        .YELLOW_CYCLES (1),
        .CLEAR_CYCLES  (2),
        .WALK_CYCLES   (2),
        .CNT_W         (8)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    function automatic logic [7:0] mk(input logic [1:0] ns, input logic [1:0] ew,
                                      input logic wk, input logic pw);
        return {ns, ew, (ns != 2'b00), (ew != 2'b00), wk, pw};
    endfunction

    function automatic logic [7:0] obs_a();
        return {bus_a.ns_light, bus_a.ew_light, bus_a.ns_pass, bus_a.ew_pass, bus_a.walk, bus_a.ped_wait};
    endfunction

    function automatic logic [7:0] obs_b();
        return {bus_b.ns_light, bus_b.ew_light, bus_b.ns_pass, bus_b.ew_pass, bus_b.walk, bus_b.ped_wait};
    endfunction

    // Default-parameter lamps with no requests, {ns, ew}, period 16.
    function automatic logic [3:0] base_a(input int n);
        int m;
        m = n % 16;
        if (m <= 4)       return {LG, LR};
        else if (m <= 6)  return {LY, LR};
        else if (m == 7)  return {LR, LR};
        else if (m <= 12) return {LR, LG};
        else if (m <= 14) return {LR, LY};
        else              return {LR, LR};
    endfunction

    // Small-parameter lamps with no requests, {ns, ew}, period 12.
    function automatic logic [3:0] base_b(input int n);
        int m;
        m = n % 12;
        if (m <= 2)       return {LG, LR};
        else if (m == 3)  return {LY, LR};
        else if (m <= 5)  return {LR, LR};
        else if (m <= 8)  return {LR, LG};
        else if (m == 9)  return {LR, LY};
        else              return {LR, LR};
    endfunction

    task automatic tick(input logic req_a, input logic req_b);
        bus_a.ped_req = req_a;
        bus_b.ped_req = req_b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.ped_req = 1'b0;
        bus_b.ped_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        do_reset();
        e = mk(LG, LR, 1'b0, 1'b0);
        n_run++;
        if (obs_a() !== e) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected %b", obs_a(), e);
        end
        n_run++;
        if (obs_b() !== e) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected %b", obs_b(), e);
        end
    endtask

    task automatic test_free_run();
        logic [3:0] l;
        logic [7:0] e;
        do_reset();
        for (int n = 0; n <= 24; n++) begin
            if (n > 0) tick(1'b0, 1'b0);
            l = base_a(n);
            e = mk(l[3:2], l[1:0], 1'b0, 1'b0);
            n_run++;
            if (obs_a() !== e) begin
                n_fail++;
                $display("FAIL free_run_a N=%0d: got %b expected %b", n, obs_a(), e);
            end
            l = base_b(n);
            e = mk(l[3:2], l[1:0], 1'b0, 1'b0);
            n_run++;
            if (obs_b() !== e) begin
                n_fail++;
                $display("FAIL free_run_b N=%0d: got %b expected %b", n, obs_b(), e);
            end
        end
    endtask

    // Single request on edge N=2; with extra=1 another request lands on the WALK-entry edge N=8.
    task automatic test_single_request(input logic extra);
        logic [3:0] l;
        logic [7:0] e;
        logic       pw;
        do_reset();
        for (int n = 0; n <= 24; n++) begin
            if (n > 0) tick((n == 2) || (extra && (n == 8)), 1'b0);
            pw = (n >= 2) && (n <= 7);
            if (n <= 7) begin
                l = base_a(n);
                e = mk(l[3:2], l[1:0], 1'b0, pw);
            end else if (n <= 11) e = mk(LR, LR, 1'b1, 1'b0);
            else if (n <= 16)     e = mk(LR, LG, 1'b0, 1'b0);
            else if (n <= 18)     e = mk(LR, LY, 1'b0, 1'b0);
            else if (n == 19)     e = mk(LR, LR, 1'b0, 1'b0);
            else                  e = mk(LG, LR, 1'b0, 1'b0);
            n_run++;
            if (obs_a() !== e) begin
                n_fail++;
                $display("FAIL %s N=%0d: got %b expected %b",
                         extra ? "req_on_walk_entry" : "single_request", n, obs_a(), e);
            end
        end
    endtask

    task automatic test_held_request();
        logic [3:0] l;
        logic [7:0] e;
        do_reset();
        for (int n = 0; n <= 26; n++) begin
            if (n > 0) tick((n >= 2) && (n <= 20), 1'b0);
            if (n <= 7) begin
                l = base_a(n);
                e = mk(l[3:2], l[1:0], 1'b0, (n >= 2));
            end else if (n <= 11) e = mk(LR, LR, 1'b1, 1'b0);
            else if (n <= 16)     e = mk(LR, LG, 1'b0, 1'b1);
            else if (n <= 18)     e = mk(LR, LY, 1'b0, 1'b1);
            else if (n == 19)     e = mk(LR, LR, 1'b0, 1'b1);
            else if (n <= 23)     e = mk(LR, LR, 1'b1, 1'b0);
            else                  e = mk(LG, LR, 1'b0, 1'b0);
            n_run++;
            if (obs_a() !== e) begin
                n_fail++;
                $display("FAIL held_request N=%0d: got %b expected %b", n, obs_a(), e);
            end
        end
    endtask

    // Request at N=9 during EW green, then reset (with ped_req high) at what would be N=11.
    task automatic test_mid_reset();
        logic [3:0] l;
        logic [7:0] e;
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            tick(n == 9, 1'b0);
            if (n >= 9) begin
                e = mk(LR, LG, 1'b0, 1'b1);
                n_run++;
                if (obs_a() !== e) begin
                    n_fail++;
                    $display("FAIL mid_reset_pre N=%0d: got %b expected %b", n, obs_a(), e);
                end
            end
        end
        rst = 1'b1;
        tick(1'b1, 1'b1);
        rst = 1'b0;
        e = mk(LG, LR, 1'b0, 1'b0);
        n_run++;
        if (obs_a() !== e) begin
            n_fail++;
            $display("FAIL mid_reset_a: got %b expected %b", obs_a(), e);
        end
        n_run++;
        if (obs_b() !== e) begin
            n_fail++;
            $display("FAIL mid_reset_b: got %b expected %b", obs_b(), e);
        end
        for (int n = 1; n <= 9; n++) begin
            tick(1'b0, 1'b0);
            l = base_a(n);
            e = mk(l[3:2], l[1:0], 1'b0, 1'b0);
            n_run++;
            if (obs_a() !== e) begin
                n_fail++;
                $display("FAIL mid_reset_restart N=%0d: got %b expected %b", n, obs_a(), e);
            end
        end
    endtask

    // Small-parameter instance, request at N=1: clear 4..5, WALK 6..7, EW green 8..10.
    task automatic test_params_walk();
        logic [7:0] e;
        do_reset();
        for (int n = 0; n <= 15; n++) begin
            if (n > 0) tick(1'b0, n == 1);
            if (n <= 2)       e = mk(LG, LR, 1'b0, (n >= 1));
            else if (n == 3)  e = mk(LY, LR, 1'b0, 1'b1);
            else if (n <= 5)  e = mk(LR, LR, 1'b0, 1'b1);
            else if (n <= 7)  e = mk(LR, LR, 1'b1, 1'b0);
            else if (n <= 10) e = mk(LR, LG, 1'b0, 1'b0);
            else if (n == 11) e = mk(LR, LY, 1'b0, 1'b0);
            else if (n <= 13) e = mk(LR, LR, 1'b0, 1'b0);
            else              e = mk(LG, LR, 1'b0, 1'b0);
            n_run++;
            if (obs_b() !== e) begin
                n_fail++;
                $display("FAIL params_walk N=%0d: got %b expected %b", n, obs_b(), e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.ped_req = 1'b0;
        bus_b.ped_req = 1'b0;
        test_reset();
        test_free_run();
        test_single_request(1'b0);
        test_held_request();
        test_mid_reset();
        test_params_walk();
        test_single_request(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
